mm_ctrl: RTL

//  Controller at the far end of the start/FINISH handshake: on start it computes C = A x B
//  by tiling onto an external 4x4 output-stationary systolic PE array.

---
 rtl/mm_pkg.sv | 18 +
 rtl/skew_buffer.sv | 40 ++++
 rtl/mm_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared constants and types for the matrix-multiply controller.
//   T          systolic array edge (4x4 PE array)
//   DRAIN_CYC  cycles to flush the skew lanes and array after the last read
//   *_AW       SRAM address widths
//   state_t    controller FSM states
package mm_pkg;
    localparam int T         = 4;
    localparam int LANE_W    = 8;
    localparam int WORD_W    = T * LANE_W;
    localparam int DRAIN_CYC = 2 * (T - 1) + 2;
    localparam int A_AW      = 12;
    localparam int B_AW      = 12;
    localparam int C_AW      = 7;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} state_t;

    typedef logic [T-1:0][LANE_W-1:0] lanes_t;
endpackage

// File: rtl/skew_buffer.sv
// skew_buffer: staggers T byte lanes so lane r reaches the array r cycles
// after lane 0, giving the diagonal wavefront an output-stationary array needs.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   i_clr       synchronous clear of every stage
//   i_din       T lanes in (already registered by the caller)
//   o_dout      T lanes out, lane r delayed r cycles
module skew_buffer #(
    parameter int T = 4,
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic [T-1:0][W-1:0] i_din,
    output logic [T-1:0][W-1:0] o_dout
);
    for (genvar r = 0; r < T; r++) begin : g_lane
        if (r == 0) begin : g_pass
            // lane 0 has no extra delay; its input is already a register
            assign o_dout[0] = i_din[0];
        end else begin : g_sr
            logic [r-1:0][W-1:0] r_sh;
            if (r == 1) begin : g_one
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)     r_sh <= '0;
                    else if (i_clr) r_sh <= '0;
                    else            r_sh <= i_din[r];
                end
            end else begin : g_many
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)     r_sh <= '0;
                    else if (i_clr) r_sh <= '0;
                    else            r_sh <= {r_sh[r-2:0], i_din[r]};
                end
            end
            assign o_dout[r] = r_sh[r-1];
        end
    end
endmodule

// File: rtl/mm_ctrl.sv
// mm_ctrl: computes C = A x B by tiling onto an external 4x4 output-stationary
// systolic array. Per tile: CLEAR (1) -> FEED (K) -> DRAIN (8) -> WRITE (4).
// Tiles walk column tile tc first, then row tile tr; FINISH after the last.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   start, FINISH       start pulse in; done level out
//   a_addr/a_rdata      SRAM_A word port (1-cycle read latency)
//   b_addr/b_rdata      SRAM_B word port (1-cycle read latency)
//   pe_clear,pe_a,pe_b  PE array control and skewed operand lanes
//   pe_c                16 PE accumulator bytes
//   c_wen/c_addr/c_wdata  write port to the four C SRAMs
module mm_ctrl
    import mm_pkg::*;
#(
    parameter int M = 128,
    parameter int K = 16,
    parameter int N = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              FINISH,
    output logic [A_AW-1:0]   a_addr,
    input  logic [WORD_W-1:0] a_rdata,
    output logic [B_AW-1:0]   b_addr,
    input  logic [WORD_W-1:0] b_rdata,
    output logic              pe_clear,
    output logic [WORD_W-1:0] pe_a,
    output logic [WORD_W-1:0] pe_b,
    input  logic [T*T*LANE_W-1:0] pe_c,
    output logic [N/T-1:0]    c_wen,
    output logic [C_AW-1:0]   c_addr,
    output logic [WORD_W-1:0] c_wdata
);
    localparam int TR_N = M / T;
    localparam int TC_N = N / T;
    localparam int TRW  = (TR_N > 1) ? $clog2(TR_N) : 1;
    localparam int TCW  = (TC_N > 1) ? $clog2(TC_N) : 1;
    // one phase counter serves k, drain count and write row; must reach K-1 and 7
    localparam int CW   = (K > 8) ? $clog2(K) : 3;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [TCW-1:0]  r_tc;
    logic [TRW-1:0]  r_tr;
    logic            r_rd_vld;
    lanes_t          r_a_q, r_b_q;
    lanes_t          w_pe_a, w_pe_b;
    logic            w_start_ok, w_row_last, w_tile_last;

    assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
    assign w_row_last  = (r_cnt == CW'(T - 1));
    assign w_tile_last = (r_tc == TCW'(TC_N - 1)) && (r_tr == TRW'(TR_N - 1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = CLEAR;
            CLEAR:      w_next = FEED;
            FEED:       if (r_cnt == CW'(K - 1)) w_next = DRAIN;
            DRAIN:      if (r_cnt == CW'(DRAIN_CYC - 1)) w_next = WRITE;
            WRITE:      if (w_row_last) w_next = w_tile_last ? DONE : CLEAR;
            default:    w_next = IDLE;
        endcase
    end

    // outputs decoded from state and counters
    always_comb begin
        FINISH   = 1'b0;
        pe_clear = 1'b0;
        a_addr   = '0;
        b_addr   = '0;
        c_wen    = '0;
        c_addr   = '0;
        c_wdata  = '0;
        case (r_state)
            CLEAR: pe_clear = 1'b1;
            FEED: begin
                a_addr = A_AW'(r_tr) * A_AW'(K) + A_AW'(r_cnt);
                b_addr = B_AW'(r_tc) * B_AW'(K) + B_AW'(r_cnt);
            end
            WRITE: begin
                c_wen   = {{(TC_N-1){1'b0}}, 1'b1} << r_tc;
                c_addr  = C_AW'({r_tr, r_cnt[1:0]});
                c_wdata = pe_c[{r_cnt[1:0], 5'b0} +: WORD_W];
            end
            DONE: FINISH = 1'b1;
            default: ;
        endcase
    end

    // phase counter restarts on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_cnt <= '0;
        else if (w_next != r_state) r_cnt <= '0;
        else if (r_state == FEED || r_state == DRAIN || r_state == WRITE)
            r_cnt <= r_cnt + 1'b1;
    end

    // tile counters: tc fastest, tr carries when tc wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tc <= '0;
            r_tr <= '0;
        end else if (w_start_ok) begin
            r_tc <= '0;
            r_tr <= '0;
        end else if (r_state == WRITE && w_row_last) begin
            r_tc <= r_tc + 1'b1;
            if (r_tc == TCW'(TC_N - 1)) r_tr <= r_tr + 1'b1;
        end
    end

    // capture SRAM data one cycle after each FEED address; zero otherwise so
    // the lanes carry nothing outside a tile's feed window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= 1'b0;
            r_a_q    <= '0;
            r_b_q    <= '0;
        end else begin
            r_rd_vld <= (r_state == FEED);
            r_a_q    <= r_rd_vld ? lanes_t'(a_rdata) : '0;
            r_b_q    <= r_rd_vld ? lanes_t'(b_rdata) : '0;
        end
    end

    skew_buffer #(.T(T), .W(LANE_W)) u_skew_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (pe_clear),
        .i_din  (r_a_q),
        .o_dout (w_pe_a)
    );

    skew_buffer #(.T(T), .W(LANE_W)) u_skew_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (pe_clear),
        .i_din  (r_b_q),
        .o_dout (w_pe_b)
    );

    assign pe_a = w_pe_a;
    assign pe_b = w_pe_b;
endmodule
